freq_serial_loader: RTL and testbench

FREQ_SERIAL_LOADER -- requirements
Module: freq_serial_loader

---
 rtl/freq_serial_loader.sv | 175 +++++++++++++++++
 tb/tb_freq_serial_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_serial_loader.sv
// UART (8N1) loader for the clock-divider FREQ_VAL word: little-endian 4-byte frames.
// Optional FREQ_LOAD_CHECKSUM_EN adds a fifth XOR checksum byte to each frame.
module freq_serial_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
    parameter logic [31:0] RESET_FREQ   = 32'd50_000_000
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        rx,
    output logic [31:0] freq_val,
    output logic        freq_update,
    output logic        rx_err,
    output logic        busy,
    output logic [1:0]  o_state_dbg
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

`ifdef FREQ_LOAD_CHECKSUM_EN
    localparam int BIW   = 3;
    localparam int ACC_W = 32;
    localparam logic [BIW-1:0] LAST_IDX = 3'd4;
`else
    localparam int BIW   = 2;
    localparam int ACC_W = 24;
    localparam logic [BIW-1:0] LAST_IDX = 2'd3;
`endif

    localparam int TW = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [15:0]   HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    logic             r_rx_meta, r_rx_sync;
    logic [1:0]       r_state, w_state_nxt;
    logic [15:0]      r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [BIW-1:0]   r_byte_idx, w_byte_nxt;
    logic [ACC_W-1:0] r_accum, w_accum_nxt;
    logic [TW-1:0]    r_timer, w_timer_nxt;
    logic [31:0]      r_freq, w_freq_nxt;
    logic             r_update, w_update;
    logic             r_err, w_err;
    logic             r_busy, w_busy_nxt;
    logic [31:0]      w_value;
    logic             w_frame_ok;

    // Earlier bytes are shifted in from the top, so byte 0 ends up at bits 7:0.
`ifdef FREQ_LOAD_CHECKSUM_EN
    assign w_value    = r_accum;
    assign w_frame_ok = (r_accum != 32'd0) &&
                        (r_shift == (r_accum[7:0] ^ r_accum[15:8] ^ r_accum[23:16] ^ r_accum[31:24]));
`else
    assign w_value    = {r_shift, r_accum};
    assign w_frame_ok = (w_value != 32'd0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_byte_idx;
        w_accum_nxt = r_accum;
        w_timer_nxt = '0;
        w_freq_nxt  = r_freq;
        w_update    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_sync) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end else if (r_byte_idx != '0) begin
                    if (r_timer == TMO_LAST) begin
                        w_byte_nxt  = '0;
                        w_accum_nxt = '0;
                        w_err       = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            ST_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (!r_rx_sync) begin
                        w_byte_nxt  = '0;
                        w_accum_nxt = '0;
                        w_err       = 1'b1;
                    end else if (r_byte_idx == LAST_IDX) begin
                        w_byte_nxt  = '0;
                        w_accum_nxt = '0;
                        if (w_frame_ok) begin
                            w_freq_nxt = w_value;
                            w_update   = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else begin
                        w_accum_nxt = {r_shift, r_accum[ACC_W-1:8]};
                        w_byte_nxt  = r_byte_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE) || (w_byte_nxt != '0);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_accum    <= '0;
            r_timer    <= '0;
            r_freq     <= RESET_FREQ;
            r_update   <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_byte_idx <= w_byte_nxt;
            r_accum    <= w_accum_nxt;
            r_timer    <= w_timer_nxt;
            r_freq     <= w_freq_nxt;
            r_update   <= w_update;
            r_err      <= w_err;
            r_busy     <= w_busy_nxt;
        end
    end

    assign freq_val    = r_freq;
    assign freq_update = r_update;
    assign rx_err      = r_err;
    assign busy        = r_busy;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_freq_serial_loader.sv
// Directed bench for freq_serial_loader: table of frames plus hand-written corner sequences.
module tb_freq_serial_loader;

    localparam int CPB = 16;
    localparam int TMO = 320;

    logic        clk_in  = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx      = 1'b1;
    logic [31:0] freq_val;
    logic        freq_update;
    logic        rx_err;
    logic        busy;
    logic [1:0]  o_state_dbg;

    freq_serial_loader #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO),
        .RESET_FREQ  (32'd50_000_000)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .rx         (rx),
        .freq_val   (freq_val),
        .freq_update(freq_update),
        .rx_err     (rx_err),
        .busy       (busy),
        .o_state_dbg(o_state_dbg)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_upd = 0;
    int n_err = 0;
    int n_both = 0;
    int last_err_cyc = 0;
    logic busy_seen = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (freq_update) n_upd++;
        if (rx_err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (freq_update && rx_err) n_both++;
        if (busy) busy_seen = 1'b1;
    end

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [31:0] exp_freq;
        int          exp_upd;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[31:24], 1'b1);
`ifdef FREQ_LOAD_CHECKSUM_EN
        send_byte(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24], 1'b1);
`endif
        idle(8);
    endtask

    initial begin
        int u0;
        int e0;
        int t_end;
        int dt;

        vecs[0] = '{"frame_1M",   32'h000F4240, 32'h000F4240, 1, 0};
        vecs[1] = '{"frame_8",    32'h00000008, 32'h00000008, 1, 0};
        vecs[2] = '{"frame_zero", 32'h00000000, 32'h00000008, 0, 1};
        vecs[3] = '{"frame_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0};
        vecs[4] = '{"frame_mix",  32'h12345678, 32'h12345678, 1, 0};

        // Reset state
        idle(3);
        check("rst_freq", freq_val, 32'd50_000_000);
        check("rst_upd", {31'd0, freq_update}, 32'd0);
        check("rst_err", {31'd0, rx_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, o_state_dbg}, 32'd0);
        reset_n = 1'b1;

        // Quiet line after reset
        n_upd = 0;
        n_err = 0;
        busy_seen = 1'b0;
        idle(2000);
        check("quiet_freq", freq_val, 32'd50_000_000);
        check("quiet_upd", n_upd, 0);
        check("quiet_err", n_err, 0);
        check("quiet_busy", {31'd0, busy_seen}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            u0 = n_upd;
            e0 = n_err;
            send_frame(vecs[i].data);
            check({vecs[i].name, "_freq"}, freq_val, vecs[i].exp_freq);
            check({vecs[i].name, "_upd"}, n_upd - u0, vecs[i].exp_upd);
            check({vecs[i].name, "_err"}, n_err - e0, vecs[i].exp_err);
            check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd0);
        end

        // Bad stop bit
        u0 = n_upd;
        e0 = n_err;
        send_byte(8'h10, 1'b0);
        idle(30);
        check("stop_err", n_err - e0, 1);
        check("stop_upd", n_upd - u0, 0);
        check("stop_freq", freq_val, 32'h12345678);
        check("stop_busy", {31'd0, busy}, 32'd0);
        send_frame(32'h00000008);
        check("after_stop_freq", freq_val, 32'h00000008);

        // Inter-byte timeout
        e0 = n_err;
        u0 = n_upd;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        t_end = cyc;
        check("tmo_busy_mid", {31'd0, busy}, 32'd1);
        idle(400);
        dt = last_err_cyc - t_end;
        check("tmo_err", n_err - e0, 1);
        check("tmo_when", {31'd0, (dt >= 300) && (dt <= 330)}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_freq", freq_val, 32'h00000008);
        check("tmo_upd", n_upd - u0, 0);
        send_frame(32'h00001234);
        check("after_tmo_freq", freq_val, 32'h00001234);

        // Short low glitch
        e0 = n_err;
        u0 = n_upd;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        check("glitch_err", n_err - e0, 0);
        check("glitch_upd", n_upd - u0, 0);
        check("glitch_freq", freq_val, 32'h00001234);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_state", {30'd0, o_state_dbg}, 32'd0);

`ifdef FREQ_LOAD_CHECKSUM_EN
        e0 = n_err;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(8);
        check("chk_bad_err", n_err - e0, 1);
        check("chk_bad_freq", freq_val, 32'h00001234);
`endif

        // Reset in the middle of the third byte
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        reset_n = 1'b0;
        #1;
        check("midrst_freq", freq_val, 32'd50_000_000);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_state", {30'd0, o_state_dbg}, 32'd0);
        idle(5);
        reset_n = 1'b1;
        idle(20);
        u0 = n_upd;
        send_frame(32'h00000064);
        check("midrst_next_freq", freq_val, 32'd100);
        check("midrst_next_upd", n_upd - u0, 1);

        check("no_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
